// File: rtl/btn_sel_debounce_pkg.sv
// Shared definitions for push-button debouncing blocks.
package btn_sel_debounce_pkg;

  // Default debounce window in clock cycles.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

endpackage : btn_sel_debounce_pkg

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous board inputs, resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // Shift the raw level through two flops to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule : sync2

// File: rtl/btn_sel_debounce.sv
// Push-button debouncer producing a toggle select plus press/release pulses.
module btn_sel_debounce
  import btn_sel_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter logic        SEL_INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic sel,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             b_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (b_s)
  );

  // Debounce FSM: a new level is accepted only after it holds for the full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      sel           <= SEL_INIT;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (b_s) begin
            state <= ST_PRESS_WAIT;
          end
        end
        ST_PRESS_WAIT: begin
          if (!b_s) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= ST_HELD;
            cnt         <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
            sel         <= ~sel;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          cnt <= '0;
          if (!b_s) begin
            state <= ST_RELEASE_WAIT;
          end
        end
        ST_RELEASE_WAIT: begin
          if (b_s) begin
            state <= ST_HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule : btn_sel_debounce

// File: tb/tb_btn_sel_debounce.sv
// Self-checking bench for btn_sel_debounce with a run-length reference model.
module tb_btn_sel_debounce;

  localparam int unsigned D = 4;
  localparam logic SEL_INIT = 1'b0;

  logic clk;
  logic rst;
  logic btn_in;
  logic sel;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;

  int n_checks;
  int n_errors;

  // Reference model: history of edge-sampled inputs and accepted level.
  logic h1, h2;
  logic m_level, m_sel, m_press, m_rel;
  int   run;

  int press_seen;
  int release_seen;

  btn_sel_debounce #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           ($clog2(D)),
    .SEL_INIT        (SEL_INIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .sel           (sel),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    h1 = 1'b0; h2 = 1'b0;
    m_level = 1'b0; m_sel = SEL_INIT;
    m_press = 1'b0; m_rel = 1'b0;
    run = 0;
  endtask

  // One clock edge of the model: the debouncer acts on the input sampled two edges ago,
  // and accepts a new level once it has been seen on D+1 consecutive edges.
  task automatic model_edge(input logic b);
    logic seen;
    seen = h2;
    h2 = h1;
    h1 = b;
    m_press = 1'b0;
    m_rel = 1'b0;
    if (seen != m_level) begin
      run++;
      if (run == int'(D) + 1) begin
        m_level = seen;
        run = 0;
        if (seen) begin
          m_press = 1'b1;
          m_sel = ~m_sel;
        end else begin
          m_rel = 1'b1;
        end
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".sel"}, int'(sel), int'(m_sel));
    check_val({tag, ".level"}, int'(btn_level), int'(m_level));
    check_val({tag, ".press"}, int'(press_pulse), int'(m_press));
    check_val({tag, ".release"}, int'(release_pulse), int'(m_rel));
  endtask

  // Drive one input level for one cycle; starts and ends at a falling edge.
  task automatic tick(input logic b, input string tag);
    btn_in = b;
    @(posedge clk);
    model_edge(b);
    @(negedge clk);
    check_outputs(tag);
    if (press_pulse === 1'b1) press_seen++;
    if (release_pulse === 1'b1) release_seen++;
  endtask

  // Assert reset between edges, check immediate effect, release at a falling edge.
  task automatic apply_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs({tag, ".async"});
    @(posedge clk);
    @(negedge clk);
    check_outputs({tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    int pc, rc;
    logic lvl;
    int len;

    n_checks = 0;
    n_errors = 0;
    press_seen = 0;
    release_seen = 0;
    rst = 1'b1;
    btn_in = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state with button released.
    apply_reset("reset");
    check_val("reset.sel_init", int'(sel), 0);
    check_val("reset.level0", int'(btn_level), 0);

    // Clean press: accepted 6 edges after the first sampling edge.
    lat = 0;
    pc = press_seen;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1, "press");
      if (press_pulse === 1'b1 && lat == 0) lat = i;
    end
    check_val("press.latency_ticks", lat, 7);
    check_val("press.count", press_seen - pc, 1);
    check_val("press.sel", int'(sel), 1);

    // Clean release: same latency, sel unchanged.
    lat = 0;
    rc = release_seen;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b0, "release");
      if (release_pulse === 1'b1 && lat == 0) lat = i;
    end
    check_val("release.latency_ticks", lat, 7);
    check_val("release.count", release_seen - rc, 1);
    check_val("release.sel", int'(sel), 1);

    // Bounce pattern must be rejected, then a held press accepted once.
    pc = press_seen;
    rc = release_seen;
    begin
      logic [5:0] pat;
      pat = 6'b011011;
      for (int i = 0; i < 6; i++) tick(pat[i], "bounce");
    end
    for (int i = 0; i < 8; i++) tick(1'b0, "bounce_quiet");
    check_val("bounce.no_press", press_seen - pc, 0);
    check_val("bounce.no_release", release_seen - rc, 0);
    check_val("bounce.level", int'(btn_level), 0);
    check_val("bounce.sel", int'(sel), 1);
    for (int i = 0; i < 8; i++) tick(1'b1, "bounce_hold");
    check_val("bounce.one_press", press_seen - pc, 1);
    for (int i = 0; i < 10; i++) tick(1'b0, "bounce_rel");

    // Repeated presses from reset: sel goes 1,0,1.
    apply_reset("reset2");
    pc = press_seen;
    rc = release_seen;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) tick(1'b1, "rep_press");
      check_val("rep.sel", int'(sel), (k % 2 == 0) ? 1 : 0);
      for (int i = 0; i < 10; i++) tick(1'b0, "rep_release");
    end
    check_val("rep.press_count", press_seen - pc, 3);
    check_val("rep.release_count", release_seen - rc, 3);

    // Reset mid-count with the button held; press re-debounced after reset.
    apply_reset("reset3");
    pc = press_seen;
    for (int i = 0; i < 4; i++) tick(1'b1, "midcnt_pre");
    check_val("midcnt.no_press_before_rst", press_seen - pc, 0);
    apply_reset("reset_mid");
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1, "midcnt_post");
      if (press_pulse === 1'b1 && lat == 0) lat = i;
    end
    check_val("midcnt.latency_ticks", lat, 7);
    check_val("midcnt.sel", int'(sel), 1);
    for (int i = 0; i < 10; i++) tick(1'b0, "midcnt_rel");

    // Randomised bursts of mixed lengths, with occasional resets.
    for (int r = 0; r < 120; r++) begin
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) tick(lvl, "random");
      if ($urandom_range(0, 39) == 0) apply_reset("random_reset");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_btn_sel_debounce
